// File: rtl/rand_dir_sampler.sv
// Rejection-sampling generator of random directions inside the unit ball, fed by a
// free-running random word, with optional reflection into a surface normal's hemisphere.
module rand_dir_sampler #(
  parameter int MAX_TRIES  = 16,
  parameter int HEMISPHERE = 1
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [63:0]  random,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [191:0] normal,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [191:0] dir,
  output logic         fallback,
  output logic [7:0]   tries
);

  localparam logic [7:0]  MAX_TRIES_C = 8'(MAX_TRIES);
  localparam logic        HEMI_C      = (HEMISPHERE != 0);
  localparam logic [63:0] ONE_C       = 64'h0000_0001_0000_0000;
  localparam logic [65:0] S_ONE_C     = 66'h1_0000_0000_0000_0000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRAW_X = 3'd1,
    DRAW_Y = 3'd2,
    DRAW_Z = 3'd3,
    TEST   = 3'd4,
    FLIP   = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t        state_r;
  logic [63:0]   vx_r, vy_r, vz_r;
  logic [191:0]  normal_r;
  logic [7:0]    try_cnt_r;
  logic          fb_r;

  logic [63:0]        comp_s;
  logic               unused_random_s;
  logic signed [65:0] ex_s, ey_s, ez_s;
  logic [65:0]        sum_sq_s;
  logic               accept_s;
  logic signed [98:0] dx_s, dy_s, dz_s, nx_s, ny_s, nz_s, dot_s;
  logic               flip_s;
  logic [191:0]       fb_vec_s;
  logic [191:0]       neg_s;

  // Only bits [32:0] of the random word form a Q32.32 component in [-1.0, 1.0)
  assign comp_s          = {{31{random[32]}}, random[32:0]};
  assign unused_random_s = ^random[63:33];

  assign ex_s     = {{33{vx_r[32]}}, vx_r[32:0]};
  assign ey_s     = {{33{vy_r[32]}}, vy_r[32:0]};
  assign ez_s     = {{33{vz_r[32]}}, vz_r[32:0]};
  assign sum_sq_s = ex_s * ex_s + ey_s * ey_s + ez_s * ez_s;
  assign accept_s = (sum_sq_s != 66'd0) && (sum_sq_s <= S_ONE_C);

  // Full-precision dot product; only its sign decides the reflection
  assign dx_s   = {{66{vx_r[32]}}, vx_r[32:0]};
  assign dy_s   = {{66{vy_r[32]}}, vy_r[32:0]};
  assign dz_s   = {{66{vz_r[32]}}, vz_r[32:0]};
  assign nx_s   = {{35{normal_r[63]}},  normal_r[63:0]};
  assign ny_s   = {{35{normal_r[127]}}, normal_r[127:64]};
  assign nz_s   = {{35{normal_r[191]}}, normal_r[191:128]};
  assign dot_s  = dx_s * nx_s + dy_s * ny_s + dz_s * nz_s;
  assign flip_s = HEMI_C && !fb_r && (dot_s < 99'sd0);

  assign fb_vec_s = HEMI_C ? normal_r : {ONE_C, 64'd0, 64'd0};
  assign neg_s    = {64'd0 - vz_r, 64'd0 - vy_r, 64'd0 - vx_r};

  // Request/draw/test/flip/response sequencer with all outputs registered
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      dir       <= 192'd0;
      fallback  <= 1'b0;
      tries     <= 8'd0;
      normal_r  <= 192'd0;
      vx_r      <= 64'd0;
      vy_r      <= 64'd0;
      vz_r      <= 64'd0;
      try_cnt_r <= 8'd0;
      fb_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            normal_r  <= normal;
            try_cnt_r <= 8'd1;
            in_ready  <= 1'b0;
            state_r   <= DRAW_X;
          end
        end
        DRAW_X: begin
          vx_r    <= comp_s;
          state_r <= DRAW_Y;
        end
        DRAW_Y: begin
          vy_r    <= comp_s;
          state_r <= DRAW_Z;
        end
        DRAW_Z: begin
          vz_r    <= comp_s;
          state_r <= TEST;
        end
        TEST: begin
          if (accept_s) begin
            fb_r    <= 1'b0;
            state_r <= FLIP;
          end else if (try_cnt_r < MAX_TRIES_C) begin
            try_cnt_r <= try_cnt_r + 8'd1;
            state_r   <= DRAW_X;
          end else begin
            vx_r    <= fb_vec_s[63:0];
            vy_r    <= fb_vec_s[127:64];
            vz_r    <= fb_vec_s[191:128];
            fb_r    <= 1'b1;
            state_r <= FLIP;
          end
        end
        FLIP: begin
          dir       <= flip_s ? neg_s : {vz_r, vy_r, vx_r};
          fallback  <= fb_r;
          tries     <= try_cnt_r;
          out_valid <= 1'b1;
          state_r   <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule
